// File: rtl/sram_ctl_pkg.sv
// rtl/sram_ctl_pkg.sv - shared widths, arbiter state type and flattened-bus slice helper
package sram_ctl_pkg;

   localparam int def_num_of_ports      = 16;
   localparam int def_sg_data_width     = 64;
   localparam int def_sg_address_width  = 12;
   localparam int def_sg_des_width      = 4;
   localparam int def_sg_priority_width = 3;
   localparam int def_len_width         = 8;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Low bit of field idx inside a bus built from equal-width fields, field 0 at the LSBs.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/prio_rr_arbiter.sv
// rtl/prio_rr_arbiter.sv - highest-priority requester, ties broken round-robin from rr_ptr
module prio_rr_arbiter
   import sram_ctl_pkg::*;
#(
   parameter int num_of_ports = def_num_of_ports,
   parameter int prio_width   = def_sg_priority_width,
   parameter int idx_width    = $clog2(num_of_ports)
) (
   input  logic [num_of_ports-1:0]            request,
   input  logic [num_of_ports*prio_width-1:0] priority_flat,
   input  logic [idx_width-1:0]               rr_ptr,
   output logic                               any_request,
   output logic [num_of_ports-1:0]            select_onehot,
   output logic [idx_width-1:0]               select_idx
);

   logic [prio_width-1:0] max_prio;

   assign any_request = |request;

   // Highest priority value present among the requesting ports.
   always_comb begin
      max_prio = '0;
      for (int i = 0; i < num_of_ports; i++) begin
         if (request[i] && (priority_flat[slice_lo(i, prio_width) +: prio_width] > max_prio)) begin
            max_prio = priority_flat[slice_lo(i, prio_width) +: prio_width];
         end
      end
   end

   // Walk the ports starting at rr_ptr; the first requester at max_prio wins.
   always_comb begin
      logic found;
      int   port;
      found         = 1'b0;
      port          = 0;
      select_onehot = '0;
      select_idx    = '0;
      for (int k = 0; k < num_of_ports; k++) begin
         port = (int'(rr_ptr) + k) % num_of_ports;
         if (!found && request[port] &&
             (priority_flat[slice_lo(port, prio_width) +: prio_width] == max_prio)) begin
            found               = 1'b1;
            select_onehot[port] = 1'b1;
            select_idx          = idx_width'(port);
         end
      end
   end

endmodule

// File: rtl/wr_arbiter.sv
// rtl/wr_arbiter.sv - packet-locked SRAM write arbiter with completion descriptors
module wr_arbiter
   import sram_ctl_pkg::*;
#(
   parameter int num_of_ports      = def_num_of_ports,
   parameter int sg_data_width     = def_sg_data_width,
   parameter int sg_address_width  = def_sg_address_width,
   parameter int sg_des_width      = def_sg_des_width,
   parameter int sg_priority_width = def_sg_priority_width,
   parameter int len_width         = def_len_width
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [num_of_ports-1:0]                   request,
   input  logic [num_of_ports*sg_priority_width-1:0] wr_priority,
   input  logic [num_of_ports*sg_des_width-1:0]      des_port,
   input  logic [num_of_ports*sg_address_width-1:0]  address_write,
   input  logic [num_of_ports*sg_data_width-1:0]     data_write,
   input  logic [num_of_ports-1:0]                   eop,
   output logic [num_of_ports-1:0]                   grant,
   output logic                                      sram_we,
   output logic [sg_address_width-1:0]               sram_addr,
   output logic [sg_data_width-1:0]                  sram_wdata,
   output logic                                      pkt_done,
   output logic [sg_des_width-1:0]                   pkt_des,
   output logic [sg_priority_width-1:0]              pkt_priority,
   output logic [sg_address_width-1:0]               pkt_start_addr,
   output logic [len_width-1:0]                      pkt_len
);

   localparam int iw = $clog2(num_of_ports);

   arb_state_t                   state, state_next;
   logic [iw-1:0]                sel_idx, rr_ptr;
   logic [sg_priority_width-1:0] sel_prio;
   logic [sg_des_width-1:0]      sel_des;
   logic [len_width-1:0]         word_cnt;
   logic [sg_address_width-1:0]  start_addr;
   logic                         arb_any;
   logic [num_of_ports-1:0]      arb_onehot;
   logic [iw-1:0]                arb_idx;
   logic                         word_accept, word_last;
   logic [sg_address_width-1:0]  sel_addr;
   logic [sg_data_width-1:0]     sel_data;

   prio_rr_arbiter #(
      .num_of_ports (num_of_ports),
      .prio_width   (sg_priority_width),
      .idx_width    (iw)
   ) u_prio_rr_arbiter (
      .request       (request),
      .priority_flat (wr_priority),
      .rr_ptr        (rr_ptr),
      .any_request   (arb_any),
      .select_onehot (arb_onehot),
      .select_idx    (arb_idx)
   );

   assign sel_addr = address_write[slice_lo(int'(sel_idx), sg_address_width) +: sg_address_width];
   assign sel_data = data_write[slice_lo(int'(sel_idx), sg_data_width) +: sg_data_width];

   // Next state; only the locked port can deliver words, and only while in BURST.
   always_comb begin
      state_next  = state;
      word_accept = 1'b0;
      word_last   = 1'b0;
      case (state)
         ARB: begin
            if (arb_any) state_next = BURST;
         end
         BURST: begin
            word_accept = request[sel_idx];
            word_last   = word_accept && eop[sel_idx];
            if (word_last) state_next = ARB;
         end
         default: state_next = ARB;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ARB;
      else     state <= state_next;
   end

   // Lock onto the winner for the packet; advance the round-robin pointer at end of packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant    <= '0;
         sel_idx  <= '0;
         sel_prio <= '0;
         sel_des  <= '0;
         rr_ptr   <= '0;
      end else if (state == ARB && arb_any) begin
         grant    <= arb_onehot;
         sel_idx  <= arb_idx;
         sel_prio <= wr_priority[slice_lo(int'(arb_idx), sg_priority_width) +: sg_priority_width];
         sel_des  <= des_port[slice_lo(int'(arb_idx), sg_des_width) +: sg_des_width];
      end else if (word_last) begin
         grant  <= '0;
         rr_ptr <= (sel_idx == iw'(num_of_ports - 1)) ? '0 : sel_idx + 1'b1;
      end
   end

   // SRAM write port: one cycle behind acceptance, address/data hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_we <= word_accept;
         if (word_accept) begin
            sram_addr  <= sel_addr;
            sram_wdata <= sel_data;
         end
      end
   end

   // Word count, first-word address and the completion descriptor.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt       <= '0;
         start_addr     <= '0;
         pkt_done       <= 1'b0;
         pkt_des        <= '0;
         pkt_priority   <= '0;
         pkt_start_addr <= '0;
         pkt_len        <= '0;
      end else begin
         pkt_done <= word_last;
         if (state == ARB) begin
            word_cnt <= '0;
         end else if (word_accept) begin
            if (word_cnt == '0) start_addr <= sel_addr;
            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
         end
         if (word_last) begin
            pkt_des        <= sel_des;
            pkt_priority   <= sel_prio;
            pkt_start_addr <= (word_cnt == '0) ? sel_addr : start_addr;
            pkt_len        <= (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;
         end
      end
   end

endmodule
